// File: rtl/top_pkg.sv
// Shared types and constants for the pairwise Hamming-distance engine.
package top_pkg;

   typedef enum logic [2:0] {
      LDJ0  = 3'd0,
      LDJ1  = 3'd1,
      LDK0  = 3'd2,
      LDK1  = 3'd3,
      CMP   = 3'd4,
      WRMIN = 3'd5,
      WRMAX = 3'd6,
      DONE  = 3'd7
   } state_e;

   localparam logic [7:0] N_WORDS  = 8'd32;
   localparam logic [7:0] MIN_ADDR = 8'd64;
   localparam logic [7:0] MAX_ADDR = 8'd65;
   localparam logic [7:0] MIN_INIT = 8'd16;
   localparam logic [7:0] MAX_INIT = 8'd0;

   function automatic logic [4:0] popcount16(input logic [15:0] v);
      logic [4:0] c;
      c = 5'd0;
      for (int i = 0; i < 16; i++) begin
         c = c + {4'd0, v[i]};
      end
      return c;
   endfunction

endpackage

// File: rtl/top_if.sv
// Byte-wide data memory bus between the engine and its data memory.
interface top_if;
   logic       we;
   logic [7:0] addr;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (output we, output addr, output wdata, input rdata);
   modport slave  (input we, input addr, input wdata, output rdata);
endinterface

// File: rtl/top_data_mem.sv
// 256x8 data memory: combinational read, synchronous write, no reset.
module data_mem (
   input logic   clk,
   top_if.slave  bus
);
   logic [7:0] core [0:255];

   assign bus.rdata = core[bus.addr];

   // Synchronous write port
   always_ff @(posedge clk) begin
      if (bus.we) begin
         core[bus.addr] <= bus.wdata;
      end
   end
endmodule

// File: rtl/top_reg_file.sv
// 8x8 scratch register file: per-entry write enables, four read ports, no reset.
module reg_file (
   input  logic            clk,
   input  logic [7:0]      we,
   input  logic [7:0][7:0] wdata,
   input  logic [3:0][2:0] raddr,
   output logic [3:0][7:0] rdata
);
   logic [7:0] Core [0:7];

   // Parallel entry writes
   always_ff @(posedge clk) begin
      for (int i = 0; i < 8; i++) begin
         if (we[i]) begin
            Core[i] <= wdata[i];
         end
      end
   end

   // Combinational read ports
   always_comb begin
      rdata = {4{8'h00}};
      for (int i = 0; i < 4; i++) begin
         rdata[i] = Core[raddr[i]];
      end
   end
endmodule

// File: rtl/top.sv
// Program-1 engine: min/max Hamming distance over all pairs of 32 words in data memory,
// results written to dm[64]/dm[65], then done.
module top
   import top_pkg::*;
(
   input  logic clk,
   input  logic reset,
   output logic done
);
   state_e          state_r, state_s;
   logic            init_r;
   logic            done_r;
   logic [15:0]     wj_r, wk_r;
   logic [4:0]      dist_s;
   logic [7:0]      jcur_s;
   logic [7:0]      rf_we_s;
   logic [7:0][7:0] rf_wd_s;
   logic [3:0][7:0] rf_rd_s;
   logic [7:0]      j_s, k_s, min_s, max_s;

   top_if mem ();

   data_mem dm (.clk(clk), .bus(mem));

   reg_file RF1 (
      .clk   (clk),
      .we    (rf_we_s),
      .wdata (rf_wd_s),
      .raddr ({3'd3, 3'd2, 3'd1, 3'd0}),
      .rdata (rf_rd_s)
   );

   assign j_s    = rf_rd_s[0];
   assign k_s    = rf_rd_s[1];
   assign min_s  = rf_rd_s[2];
   assign max_s  = rf_rd_s[3];
   assign dist_s = popcount16(wj_r ^ wk_r);
   // RF1 is not reset, so the first LDJ0 after reset uses j=0 while seeding the entries
   assign jcur_s = init_r ? 8'd0 : j_s;
   assign done   = done_r;

   // State register, word latches and first-pass flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= LDJ0;
         init_r  <= 1'b1;
         done_r  <= 1'b0;
         wj_r    <= 16'h0000;
         wk_r    <= 16'h0000;
      end else begin
         state_r <= state_s;
         done_r  <= (state_s == DONE);
         if (state_r == LDJ0) begin
            init_r <= 1'b0;
         end
         case (state_r)
            LDJ0:    wj_r[15:8] <= mem.rdata;
            LDJ1:    wj_r[7:0]  <= mem.rdata;
            LDK0:    wk_r[15:8] <= mem.rdata;
            LDK1:    wk_r[7:0]  <= mem.rdata;
            default: begin end
         endcase
      end
   end

   // Next state, memory bus and register-file updates
   always_comb begin
      state_s   = state_r;
      rf_we_s   = 8'h00;
      rf_wd_s   = {8{8'h00}};
      mem.we    = 1'b0;
      mem.addr  = 8'h00;
      mem.wdata = 8'h00;
      case (state_r)
         LDJ0: begin
            mem.addr = {jcur_s[6:0], 1'b0};
            if (init_r) begin
               rf_we_s[0] = 1'b1;
               rf_wd_s[0] = 8'd0;
               rf_we_s[2] = 1'b1;
               rf_wd_s[2] = MIN_INIT;
               rf_we_s[3] = 1'b1;
               rf_wd_s[3] = MAX_INIT;
            end else begin
               rf_we_s[0] = 1'b0;
            end
            state_s = LDJ1;
         end
         LDJ1: begin
            mem.addr   = {j_s[6:0], 1'b1};
            rf_we_s[1] = 1'b1;
            rf_wd_s[1] = j_s + 8'd1;
            state_s    = LDK0;
         end
         LDK0: begin
            mem.addr = {k_s[6:0], 1'b0};
            state_s  = LDK1;
         end
         LDK1: begin
            mem.addr = {k_s[6:0], 1'b1};
            state_s  = CMP;
         end
         CMP: begin
            if ({3'd0, dist_s} < min_s) begin
               rf_we_s[2] = 1'b1;
               rf_wd_s[2] = {3'd0, dist_s};
            end else begin
               rf_we_s[2] = 1'b0;
            end
            if ({3'd0, dist_s} > max_s) begin
               rf_we_s[3] = 1'b1;
               rf_wd_s[3] = {3'd0, dist_s};
            end else begin
               rf_we_s[3] = 1'b0;
            end
            if (k_s < N_WORDS - 8'd1) begin
               rf_we_s[1] = 1'b1;
               rf_wd_s[1] = k_s + 8'd1;
               state_s    = LDK0;
            end else if (j_s < N_WORDS - 8'd2) begin
               rf_we_s[0] = 1'b1;
               rf_wd_s[0] = j_s + 8'd1;
               state_s    = LDJ0;
            end else begin
               state_s = WRMIN;
            end
         end
         WRMIN: begin
            mem.we    = 1'b1;
            mem.addr  = MIN_ADDR;
            mem.wdata = min_s;
            state_s   = WRMAX;
         end
         WRMAX: begin
            mem.we    = 1'b1;
            mem.addr  = MAX_ADDR;
            mem.wdata = max_s;
            state_s   = DONE;
         end
         DONE: begin
            state_s = DONE;
         end
         default: begin
            state_s = LDJ0;
         end
      endcase
   end
endmodule

// File: tb/tb_top.sv
// Directed and seeded-random checks of the pairwise Hamming min/max engine.
module tb_top;
   logic clk;
   logic reset;
   logic done;

   logic [15:0] w [32];
   int          errors;
   int          checks;

   top dut (.clk(clk), .reset(reset), .done(done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Loads words into dm[0..63], a known pattern into dm[64..255], junk into RF1
   task automatic preset();
      for (int i = 0; i < 32; i++) begin
         dut.dm.core[2*i]   = w[i][15:8];
         dut.dm.core[2*i+1] = w[i][7:0];
      end
      for (int a = 64; a < 256; a++) begin
         dut.dm.core[a] = 8'(a) ^ 8'h5A;
      end
      for (int r = 0; r < 8; r++) begin
         dut.RF1.Core[r] = 8'hEE;
      end
   endtask

   task automatic start_run();
      reset = 1'b0;
      repeat (2) @(posedge clk);
      preset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic count_to_done(output int edges);
      edges = 0;
      while (edges < 2000) begin
         @(posedge clk);
         edges++;
         #1;
         if (done === 1'b1) break;
      end
      if (done !== 1'b1) edges = -1;
   endtask

   // Number of bytes outside dm[64..65] that differ from what preset() wrote
   function automatic int bad_bytes();
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         if (dut.dm.core[2*i] !== w[i][15:8]) n++;
         if (dut.dm.core[2*i+1] !== w[i][7:0]) n++;
      end
      for (int a = 66; a < 256; a++) begin
         if (dut.dm.core[a] !== (8'(a) ^ 8'h5A)) n++;
      end
      return n;
   endfunction

   task automatic golden(output logic [7:0] mn, output logic [7:0] mx);
      logic [7:0] d;
      mn = 8'd16;
      mx = 8'd0;
      for (int j = 0; j < 31; j++) begin
         for (int k = j + 1; k < 32; k++) begin
            d = 8'($countones(w[j] ^ w[k]));
            if (d < mn) mn = d;
            if (d > mx) mx = d;
         end
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++) w[i] = 16'h0000;
      reset = 1'b0;
      #1;
      preset();
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL reset_hold_done: got %b expected 0", done); end
      checks++;
      if (dut.dm.core[64] !== 8'h1A) begin errors++; $display("FAIL reset_no_write: got %h expected 1a", dut.dm.core[64]); end
   endtask

   task automatic test_zeros();
      int e;
      for (int i = 0; i < 32; i++) w[i] = 16'h0000;
      start_run();
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL zeros_done_low: got %b expected 0", done); end
      count_to_done(e);
      checks++;
      if (e !== 1552) begin errors++; $display("FAIL zeros_edges: got %0d expected 1552", e); end
      checks++;
      if (dut.dm.core[64] !== 8'd0) begin errors++; $display("FAIL zeros_min: got %0d expected 0", dut.dm.core[64]); end
      checks++;
      if (dut.dm.core[65] !== 8'd0) begin errors++; $display("FAIL zeros_max: got %0d expected 0", dut.dm.core[65]); end
      checks++;
      if (bad_bytes() !== 0) begin errors++; $display("FAIL zeros_untouched: got %0d bad bytes expected 0", bad_bytes()); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b1) begin errors++; $display("FAIL zeros_done_sticky: got %b expected 1", done); end
   endtask

   task automatic test_directed();
      int         e;
      logic [7:0] exp_max [3];
      exp_max = '{8'd16, 8'd16, 8'd2};
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < 32; i++) begin
            case (t)
               0:       w[i] = (i == 5) ? 16'hFFFF : 16'h0000;
               1:       w[i] = i[0] ? 16'hAAAA : 16'h5555;
               default: w[i] = 16'(1) << (i % 16);
            endcase
         end
         start_run();
         count_to_done(e);
         checks++;
         if (e !== 1552) begin errors++; $display("FAIL dir%0d_edges: got %0d expected 1552", t, e); end
         checks++;
         if (dut.dm.core[64] !== 8'd0) begin errors++; $display("FAIL dir%0d_min: got %0d expected 0", t, dut.dm.core[64]); end
         checks++;
         if (dut.dm.core[65] !== exp_max[t]) begin errors++; $display("FAIL dir%0d_max: got %0d expected %0d", t, dut.dm.core[65], exp_max[t]); end
         checks++;
         if (bad_bytes() !== 0) begin errors++; $display("FAIL dir%0d_untouched: got %0d bad bytes expected 0", t, bad_bytes()); end
      end
   endtask

   task automatic fill_random(input logic [31:0] seed);
      logic [31:0] s;
      s = seed;
      for (int i = 0; i < 32; i++) begin
         s = s ^ (s << 13);
         s = s ^ (s >> 17);
         s = s ^ (s << 5);
         w[i] = s[23:8];
      end
   endtask

   task automatic test_random();
      int         e;
      logic [7:0] mn, mx;
      for (int set = 0; set < 10; set++) begin
         fill_random(32'h1234_5677 + 32'(set) * 32'd7919);
         golden(mn, mx);
         start_run();
         count_to_done(e);
         checks++;
         if (e !== 1552) begin errors++; $display("FAIL rnd%0d_edges: got %0d expected 1552", set, e); end
         checks++;
         if (dut.dm.core[64] !== mn) begin errors++; $display("FAIL rnd%0d_min: got %0d expected %0d", set, dut.dm.core[64], mn); end
         checks++;
         if (dut.dm.core[65] !== mx) begin errors++; $display("FAIL rnd%0d_max: got %0d expected %0d", set, dut.dm.core[65], mx); end
         checks++;
         if (bad_bytes() !== 0) begin errors++; $display("FAIL rnd%0d_untouched: got %0d bad bytes expected 0", set, bad_bytes()); end
      end
   endtask

   task automatic test_mid_reset();
      int         e;
      logic [7:0] mn, mx;
      fill_random(32'hCAFE_F00D);
      golden(mn, mx);
      start_run();
      repeat (700) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL mid_done_700: got %b expected 0", done); end
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL mid_done_in_reset: got %b expected 0", done); end
      checks++;
      if (dut.dm.core[64] !== 8'h1A) begin errors++; $display("FAIL mid_min_kept: got %h expected 1a", dut.dm.core[64]); end
      checks++;
      if (dut.dm.core[65] !== 8'h1B) begin errors++; $display("FAIL mid_max_kept: got %h expected 1b", dut.dm.core[65]); end
      @(negedge clk);
      reset = 1'b1;
      count_to_done(e);
      checks++;
      if (e !== 1552) begin errors++; $display("FAIL mid_edges: got %0d expected 1552", e); end
      checks++;
      if (dut.dm.core[64] !== mn) begin errors++; $display("FAIL mid_min: got %0d expected %0d", dut.dm.core[64], mn); end
      checks++;
      if (dut.dm.core[65] !== mx) begin errors++; $display("FAIL mid_max: got %0d expected %0d", dut.dm.core[65], mx); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b0;
      test_reset();
      test_zeros();
      test_directed();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/top.md
# top

Dedicated program-1 engine: finds the minimum and maximum Hamming distance over all 496 unordered pairs of 32 16-bit words held in its internal data memory. It writes the results back to memory and raises `done`. It is the top level of the design. The bench preloads memory hierarchically, holds reset, releases it, then waits for `done`.

## Interface
- Parameters: none. Sizes are fixed constants in the package.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-low. Low aborts any run and holds the engine at its start state.
- `done`  output  1  high when results are in memory. Reset value 0.
- Required hierarchical names, used for bench preload and check:
  - `dm.core[0:255]`: 8-bit data memory.
  - `RF1.Core[0:7]`: 8-bit scratch register file.

## Operation
- Input word i (i = 0..31) is {dm.core[2i], dm.core[2i+1]}: even address is the high byte.
- Distance = popcount(word_j XOR word_k), 5 bits, range 0..16.
- Evaluate pairs j = 0..30, k = j+1..31 in ascending order.
- Running min starts at 16; running max starts at 0.
- Update min only when dist < min; update max only when dist > max (strict compares).
- At completion:
  - dm.core[64] = min, zero-extended to 8 bits.
  - dm.core[65] = max, zero-extended to 8 bits.
  - No other memory location is written.
- Reset does not clear dm or RF1.
  - The engine initialises every RF1 entry it uses when it leaves reset.
  - Values preloaded into RF1 are don't-care.
  - RF1 usage: Core[0]=j, Core[1]=k, Core[2]=min, Core[3]=max.
- FSM states and transitions:
  - LDJ0: latch high byte of word j. Entered out of reset with j=0, min=16, max=0.
  - LDJ1: latch low byte of word j; set k=j+1.
  - LDK0: latch high byte of word k.
  - LDK1: latch low byte of word k.
  - CMP: update min/max. Then:
    - k<31: k++, go to LDK0.
    - k=31 and j<30: j++, go to LDJ0.
    - otherwise: go to WRMIN.
  - WRMIN: write dm[64].
  - WRMAX: write dm[65].
  - DONE: terminal; `done`=1; stays until reset.
- Reset asserted mid-run: immediate return to LDJ0 and `done`=0. Partial results are never written. The next run starts from scratch.
- Duplicate words give dist 0, so min=0. All-identical data gives min=max=0.

## Timing
- dm: asynchronous (combinational) read, synchronous write. Write enable is active only in WRMIN and WRMAX.
- Edge count after reset release, first rising edge = edge 1:
  - 2 edges per j (LDJ0, LDJ1): 31×2 = 62.
  - 3 edges per pair (LDK0, LDK1, CMP): 496×3 = 1488.
  - Then WRMIN and WRMAX.
  - Total 1552 edges; `done` rises after edge 1552.
- `done` is decoded from state DONE: glitch-free, registered state.
- dm[64] and dm[65] are valid no later than the edge on which `done` rises.
- CMP reads only latched registers. The popcount is combinational, 16-input, within one cycle.

## Structure
- Package `top_pkg`:
  - state enum: LDJ0, LDJ1, LDK0, LDK1, CMP, WRMIN, WRMAX, DONE.
  - N_WORDS=32, MIN_ADDR=64, MAX_ADDR=65, MIN_INIT=16, MAX_INIT=0.
- Natural sub-modules:
  - `data_mem`, instance `dm`: 256×8, async read, sync write, no reset.
  - `reg_file`, instance `RF1`: 8×8, no reset.
- Popcount and FSM live in `top`.

## Test plan
- All 64 bytes 0x00: min=0, max=0, `done` after exactly 1552 edges.
- Word 5 = 0xFFFF, all others 0x0000: min=0, max=16.
- Words alternate 0x5555/0xAAAA: min=0, max=16.
- Word i = 1<<(i mod 16), giving duplicates: min=0, max=2.
- Ten random seeded data sets against a golden pairwise model. Also check that dm[66..255] is untouched and that inputs [0..63] are unchanged.
- Reset pulsed low for 2 cycles at edge 700 of a run: `done` stays low, dm[64..65] keep their preset values, and a fresh run completes 1552 edges after release with correct results.
